// File: rtl/output_streamer_if.sv
// Bundle between output_streamer and its surroundings: master command bus, start inputs,
// output-memory read port and the slave return bus with status.
interface output_streamer_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
);
  logic [DATA_W+5:0] master_bus;
  logic              accel_done;
  logic [ADDR_W-1:0] output_memory_offset;
  logic [LEN_W-1:0]  output_length;
  logic              mem_read_en;
  logic [ADDR_W-1:0] mem_read_addr;
  logic [DATA_W-1:0] mem_read_data;
  logic [DATA_W+5:0] slave_bus;
  logic              busy;
  logic              stream_done;

  modport master (
    output master_bus, accel_done, output_memory_offset, output_length, mem_read_data,
    input  mem_read_en, mem_read_addr, slave_bus, busy, stream_done
  );

  modport slave (
    input  master_bus, accel_done, output_memory_offset, output_length, mem_read_data,
    output mem_read_en, mem_read_addr, slave_bus, busy, stream_done
  );
endinterface

// File: rtl/output_streamer.sv
// Streams the output memory region to the master one word per acked frame; first word 3 cycles after accel_done.
// Backpressure: each frame is held until a seq-matched OUTPUT_ACK; stale or repeated acks are dropped.
module output_streamer #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input logic              master_clk,
  input logic              rst,
  output_streamer_if.slave sb
);

  typedef struct packed {
    logic              seq;
    logic [4:0]        meta;
    logic [DATA_W-1:0] data;
  } frame_t;

  localparam logic [4:0] OP_OUTPUT_ACK = 5'b01001;
  localparam logic [4:0] OP_RST        = 5'b11111;
  localparam logic [4:0] S_IDLE        = 5'b00000;
  localparam logic [4:0] S_DATA        = 5'b00111;
  localparam logic [4:0] S_DONE        = 5'b01010;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_PRESENT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  cnt_nxt;
  logic              seq;
  logic [4:0]        s_meta;
  logic [DATA_W-1:0] s_data;
  logic              rd_en;
  logic              done_pulse;

  logic [4:0]        m_meta;
  logic [DATA_W-1:0] m_data;
  logic              sync_rst;
  logic              ack_ok;
  logic              unused_bits;
  frame_t            frame;

  assign m_meta   = sb.master_bus[DATA_W+4:DATA_W];
  assign m_data   = sb.master_bus[DATA_W-1:0];
  assign sync_rst = rst || (m_meta == OP_RST);
  assign cnt_nxt  = cnt + LEN_W'(1);

  // Only the frame currently on the bus can be acked, so a held ack advances exactly once.
  assign ack_ok = (m_meta == OP_OUTPUT_ACK) && (m_data[0] == seq) &&
                  ((state == ST_PRESENT) || (state == ST_DONE));

  assign unused_bits = ^{sb.master_bus[DATA_W+5], m_data[DATA_W-1:1]};

  always_ff @(posedge master_clk) begin
    if (sync_rst) begin
      state      <= ST_IDLE;
      base       <= '0;
      len        <= '0;
      cnt        <= '0;
      seq        <= 1'b0;
      s_meta     <= S_IDLE;
      s_data     <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      done_pulse <= 1'b0;
    end else begin
      rd_en      <= 1'b0;
      done_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sb.accel_done) begin
            base <= sb.output_memory_offset;
            len  <= sb.output_length;
            cnt  <= '0;
            if (sb.output_length == '0) begin
              state  <= ST_DONE;
              s_meta <= S_DONE;
              s_data <= DATA_W'(sb.output_length);
            end else begin
              state   <= ST_FETCH;
              rd_en   <= 1'b1;
              rd_addr <= sb.output_memory_offset;
            end
          end
        end
        ST_FETCH: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          state  <= ST_PRESENT;
          s_meta <= S_DATA;
          s_data <= sb.mem_read_data;
        end
        ST_PRESENT: begin
          if (ack_ok) begin
            seq <= ~seq;
            cnt <= cnt_nxt;
            if (cnt_nxt == len) begin
              state  <= ST_DONE;
              s_meta <= S_DONE;
              s_data <= DATA_W'(len);
            end else begin
              state   <= ST_FETCH;
              s_meta  <= S_IDLE;
              s_data  <= '0;
              rd_en   <= 1'b1;
              // Address arithmetic wraps modulo the address space by width.
              rd_addr <= base + ADDR_W'(cnt_nxt);
            end
          end
        end
        ST_DONE: begin
          if (ack_ok) begin
            seq        <= ~seq;
            done_pulse <= 1'b1;
            state      <= ST_IDLE;
            s_meta     <= S_IDLE;
            s_data     <= '0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          s_meta <= S_IDLE;
          s_data <= '0;
        end
      endcase
    end
  end

  assign frame.seq  = seq;
  assign frame.meta = s_meta;
  assign frame.data = s_data;

  assign sb.slave_bus     = frame;
  assign sb.mem_read_en   = rd_en;
  assign sb.mem_read_addr = rd_addr;
  assign sb.busy          = (state != ST_IDLE);
  assign sb.stream_done   = done_pulse;

  // A presented frame never changes its seq bit while it stays on the bus.
  assert property (@(posedge master_clk) disable iff (rst)
    ((s_meta != S_IDLE) && (s_meta == $past(s_meta))) |-> (seq == $past(seq)));

  assert property (@(posedge master_clk) disable iff (rst)
    (s_meta == S_IDLE) |-> (s_data == '0));

endmodule

// File: tb/tb_output_streamer.sv
// Directed bench for output_streamer: table of per-cycle vectors plus hand-written multi-cycle sequences.
module tb_output_streamer;

  localparam logic [4:0] M_NONE = 5'h00;
  localparam logic [4:0] M_ACK  = 5'h09;
  localparam logic [4:0] M_RST  = 5'h1F;
  localparam logic [4:0] S_DATA = 5'h07;
  localparam logic [4:0] S_DONE = 5'h0A;
  localparam int NV = 22;

  typedef struct {
    logic [4:0]  m_meta;
    logic        m_bit;
    logic        acc;
    logic [15:0] off;
    logic [15:0] len;
    logic [23:0] exp_bus;
    logic        exp_en;
    logic [15:0] exp_addr;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_streamer_if #(.DATA_W(18), .ADDR_W(16), .LEN_W(16)) sif ();

  output_streamer #(.DATA_W(18), .ADDR_W(16), .LEN_W(16)) dut (
    .master_clk (clk),
    .rst        (rst),
    .sb         (sif)
  );

  logic [17:0] mem [0:65535];
  int n_reads = 0;

  always @(posedge clk) begin
    if (sif.mem_read_en) begin
      sif.mem_read_data <= mem[sif.mem_read_addr];
      n_reads           <= n_reads + 1;
    end
  end

  int   total = 0;
  int   bad   = 0;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] frm(input logic sq, input logic [4:0] meta, input logic [17:0] d);
    return {sq, meta, d};
  endfunction

  function automatic vec_t mk(input logic [4:0] mm, input logic mb, input logic acc,
                              input logic [15:0] off, input logic [15:0] len,
                              input logic [23:0] eb, input logic ee, input logic [15:0] ea,
                              input logic ebusy, input logic edone);
    vec_t v;
    v.m_meta = mm; v.m_bit = mb; v.acc = acc; v.off = off; v.len = len;
    v.exp_bus = eb; v.exp_en = ee; v.exp_addr = ea; v.exp_busy = ebusy; v.exp_done = edone;
    return v;
  endfunction

  task automatic drive_m(input logic [4:0] meta, input logic b);
    sif.master_bus = {1'b0, meta, 17'd0, b};
  endtask

  task automatic start(input logic [15:0] off, input logic [15:0] len);
    sif.accel_done           = 1'b1;
    sif.output_memory_offset = off;
    sif.output_length        = len;
    tick();
    sif.accel_done = 1'b0;
  endtask

  // Entered with the FETCH read strobe visible; leaves after the word's ack edge.
  task automatic serve(input logic [15:0] addr, input logic [17:0] d, input logic sq);
    chk("serve_rd_en", sif.mem_read_en, 1);
    chk("serve_rd_addr", sif.mem_read_addr, addr);
    tick();
    chk("serve_rd_en_drop", sif.mem_read_en, 0);
    tick();
    chk("serve_frame", sif.slave_bus, frm(sq, S_DATA, d));
    drive_m(M_ACK, sq);
    tick();
    drive_m(M_NONE, 1'b0);
  endtask

  task automatic done_frame(input logic [15:0] len, input logic sq);
    chk("done_frame", sif.slave_bus, frm(sq, S_DONE, {2'b00, len}));
    drive_m(M_ACK, sq);
    tick();
    drive_m(M_NONE, 1'b0);
    chk("done_pulse", sif.stream_done, 1);
    chk("done_busy", sif.busy, 0);
    tick();
    chk("done_pulse_end", sif.stream_done, 0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_bus"}, sif.slave_bus, 0);
    chk({tag, "_rd_en"}, sif.mem_read_en, 0);
    chk({tag, "_rd_addr"}, sif.mem_read_addr, 0);
    chk({tag, "_busy"}, sif.busy, 0);
    chk({tag, "_done"}, sif.stream_done, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk_cleared("rst");
    rst = 1'b0;
  endtask

  initial begin
    int r0;
    rst = 1'b1;
    sif.master_bus = '0;
    sif.accel_done = 1'b0;
    sif.output_memory_offset = '0;
    sif.output_length = '0;
    mem[16'h0100] = 18'h00011; mem[16'h0101] = 18'h3FFFF; mem[16'h0102] = 18'h12345;
    mem[16'h0300] = 18'h0AAAA; mem[16'h0301] = 18'h15555; mem[16'h0302] = 18'h00F0F;
    mem[16'hFFFF] = 18'h2AAAA; mem[16'h0000] = 18'h15555;
    repeat (2) tick();
    chk_cleared("init");
    rst = 1'b0;

    // Basic 3-word stream, then zero length, then start coinciding with a stale ack.
    vecs[0]  = mk(M_NONE, 0, 1, 16'h0100, 16'd3, 24'h000000, 1, 16'h0100, 1, 0);
    vecs[1]  = mk(M_NONE, 0, 0, 16'h0000, 16'd0, 24'h000000, 0, 16'h0000, 1, 0);
    vecs[2]  = mk(M_NONE, 0, 0, 16'h0000, 16'd0, 24'h1C0011, 0, 16'h0000, 1, 0);
    vecs[3]  = mk(M_ACK,  0, 0, 16'h0000, 16'd0, 24'h800000, 1, 16'h0101, 1, 0);
    vecs[4]  = mk(M_NONE, 0, 0, 16'h0000, 16'd0, 24'h800000, 0, 16'h0000, 1, 0);
    vecs[5]  = mk(M_NONE, 0, 0, 16'h0000, 16'd0, 24'h9FFFFF, 0, 16'h0000, 1, 0);
    vecs[6]  = mk(M_ACK,  1, 0, 16'h0000, 16'd0, 24'h000000, 1, 16'h0102, 1, 0);
    vecs[7]  = mk(M_NONE, 0, 0, 16'h0000, 16'd0, 24'h000000, 0, 16'h0000, 1, 0);
    vecs[8]  = mk(M_NONE, 0, 0, 16'h0000, 16'd0, 24'h1D2345, 0, 16'h0000, 1, 0);
    vecs[9]  = mk(M_ACK,  0, 0, 16'h0000, 16'd0, 24'hA80003, 0, 16'h0000, 1, 0);
    vecs[10] = mk(M_ACK,  1, 0, 16'h0000, 16'd0, 24'h000000, 0, 16'h0000, 0, 1);
    vecs[11] = mk(M_NONE, 0, 0, 16'h0000, 16'd0, 24'h000000, 0, 16'h0000, 0, 0);
    vecs[12] = mk(M_NONE, 0, 1, 16'h0200, 16'd0, 24'h280000, 0, 16'h0000, 1, 0);
    vecs[13] = mk(M_ACK,  1, 0, 16'h0000, 16'd0, 24'h280000, 0, 16'h0000, 1, 0);
    vecs[14] = mk(M_ACK,  0, 0, 16'h0000, 16'd0, 24'h800000, 0, 16'h0000, 0, 1);
    vecs[15] = mk(M_ACK,  0, 0, 16'h0000, 16'd0, 24'h800000, 0, 16'h0000, 0, 0);
    vecs[16] = mk(M_ACK,  0, 1, 16'h0100, 16'd1, 24'h800000, 1, 16'h0100, 1, 0);
    vecs[17] = mk(M_ACK,  0, 0, 16'h0000, 16'd0, 24'h800000, 0, 16'h0000, 1, 0);
    vecs[18] = mk(M_ACK,  0, 0, 16'h0000, 16'd0, 24'h9C0011, 0, 16'h0000, 1, 0);
    vecs[19] = mk(M_ACK,  1, 0, 16'h0000, 16'd0, 24'h280001, 0, 16'h0000, 1, 0);
    vecs[20] = mk(M_ACK,  1, 0, 16'h0000, 16'd0, 24'h280001, 0, 16'h0000, 1, 0);
    vecs[21] = mk(M_ACK,  0, 0, 16'h0000, 16'd0, 24'h800000, 0, 16'h0000, 0, 1);

    for (int i = 0; i < NV; i++) begin
      drive_m(vecs[i].m_meta, vecs[i].m_bit);
      sif.accel_done           = vecs[i].acc;
      sif.output_memory_offset = vecs[i].off;
      sif.output_length        = vecs[i].len;
      tick();
      chk($sformatf("v%0d_bus", i), sif.slave_bus, vecs[i].exp_bus);
      chk($sformatf("v%0d_rd_en", i), sif.mem_read_en, vecs[i].exp_en);
      if (vecs[i].exp_en)
        chk($sformatf("v%0d_rd_addr", i), sif.mem_read_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_busy", i), sif.busy, vecs[i].exp_busy);
      chk($sformatf("v%0d_done", i), sif.stream_done, vecs[i].exp_done);
    end
    drive_m(M_NONE, 1'b0);
    sif.accel_done = 1'b0;

    // Held ack on word 0, then a wrong-seq ack on word 1.
    do_reset();
    r0 = n_reads;
    start(16'h0300, 16'd3);
    chk("held_rd_addr0", sif.mem_read_addr, 16'h0300);
    tick();
    tick();
    chk("held_word0", sif.slave_bus, frm(1'b0, S_DATA, 18'h0AAAA));
    drive_m(M_ACK, 1'b0);
    repeat (5) tick();
    chk("held_word1", sif.slave_bus, frm(1'b1, S_DATA, 18'h15555));
    chk("held_reads", n_reads - r0, 2);
    repeat (3) tick();
    chk("wrong_seq_hold", sif.slave_bus, frm(1'b1, S_DATA, 18'h15555));
    drive_m(M_ACK, 1'b1);
    tick();
    drive_m(M_NONE, 1'b0);
    chk("held_release", sif.slave_bus, 0);
    serve(16'h0302, 18'h00F0F, 1'b0);
    done_frame(16'd3, 1'b1);

    // Address wrap past the top of memory.
    do_reset();
    start(16'hFFFF, 16'd2);
    serve(16'hFFFF, 18'h2AAAA, 1'b0);
    serve(16'h0000, 18'h15555, 1'b1);
    done_frame(16'd2, 1'b0);

    // Abort during word 1: first via the RST opcode, then via rst.
    do_reset();
    for (int m = 0; m < 2; m++) begin
      start(16'h0100, 16'd3);
      serve(16'h0100, 18'h00011, 1'b0);
      chk("abort_rd_addr1", sif.mem_read_addr, 16'h0101);
      tick();
      tick();
      chk("abort_word1", sif.slave_bus, frm(1'b1, S_DATA, 18'h3FFFF));
      if (m == 0) drive_m(M_RST, 1'b0);
      else rst = 1'b1;
      tick();
      drive_m(M_NONE, 1'b0);
      rst = 1'b0;
      chk_cleared($sformatf("abort%0d", m));
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("abort_no_done", sif.stream_done, 0);
        chk("abort_idle", sif.busy, 0);
      end
      start(16'h0100, 16'd3);
      serve(16'h0100, 18'h00011, 1'b0);
      serve(16'h0101, 18'h3FFFF, 1'b1);
      serve(16'h0102, 18'h12345, 1'b0);
      done_frame(16'd3, 1'b1);
    end

    // accel_done while busy must not disturb base, length or count.
    start(16'h0300, 16'd2);
    chk("busy_rd_addr0", sif.mem_read_addr, 16'h0300);
    sif.accel_done = 1'b1;
    sif.output_memory_offset = 16'h0500;
    sif.output_length = 16'd7;
    tick();
    sif.accel_done = 1'b0;
    tick();
    chk("busy_word0", sif.slave_bus, frm(1'b0, S_DATA, 18'h0AAAA));
    r0 = n_reads;
    sif.accel_done = 1'b1;
    tick();
    sif.accel_done = 1'b0;
    chk("busy_present_hold", sif.slave_bus, frm(1'b0, S_DATA, 18'h0AAAA));
    chk("busy_present_noread", n_reads - r0, 0);
    drive_m(M_ACK, 1'b0);
    tick();
    drive_m(M_NONE, 1'b0);
    serve(16'h0301, 18'h15555, 1'b1);
    done_frame(16'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_streamer.md
Name: output_streamer

Overview:
- Slave-to-master transmitter; the return direction of the 24-bit master_bus command protocol.
- When the accelerator finishes, it reads the output region of the shared memory and streams it word by word to the master on slave_bus.
- Each word is held until the master acknowledges it with PROTOCOL_OUTPUT_ACK on master_bus.
- Sits beside the command interface and shares the master_bus decode (meta [22:18], data [17:0]) and opcode values.

Parameters:
- DATA_W, 18, memory word / bus data width.
- ADDR_W, 16, memory address width.
- LEN_W, 16, width of the output word count.

Ports:
- master_clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- master_bus  in  24  master command bus; meta=[22:18], data=[17:0].
- accel_done  in  1  one-cycle pulse from the accelerator: output memory complete.
- output_memory_offset  in  ADDR_W  base address of the output region; sampled at start.
- output_length  in  LEN_W  number of words to send; sampled at start.
- mem_read_en  out  1  read strobe to the output memory port.
- mem_read_addr  out  ADDR_W  read address.
- mem_read_data  in  DATA_W  read data, valid exactly 1 cycle after mem_read_en.
- slave_bus  out  24  [23]=seq, [22:18]=slave meta, [17:0]=data.
- busy  out  1  high from start until return to IDLE.
- stream_done  out  1  one-cycle pulse when the DONE frame is acknowledged.

Behaviour:
- Opcodes:
  - Master opcodes: OUTPUT_ACK=5'b01001, RST=5'b11111.
  - Slave metas: S_IDLE=5'b00000, S_DATA=5'b00111, S_DONE=5'b01010.
- Reset:
  - rst, or master meta==RST, is a synchronous reset. It forces state IDLE and clears every output.
  - Reset values: slave_bus=0, mem_read_en=0, mem_read_addr=0, busy=0, stream_done=0.
  - Internal state also clears: seq=0, word counter=0.
  - Reset mid-stream aborts the stream; no DONE frame is sent.
- Valid ack: master meta==OUTPUT_ACK && master_data[0]==slave_bus[23].
  - Any other ack is ignored: wrong seq, stale, repeated, or received outside PRESENT/DONE.
  - This lets the master hold OUTPUT_ACK for many cycles safely.
- States:
  - IDLE:
    - Outputs: slave_bus meta=S_IDLE, busy=0.
    - accel_done=1: latch base=output_memory_offset, len=output_length; clear cnt; seq keeps its value.
    - If len==0 go to DONE, else go to FETCH.
  - FETCH (1 cycle):
    - mem_read_en=1, mem_read_addr=base+cnt, modulo 2^ADDR_W (wraps past 0xFFFF).
    - Go to WAIT.
  - WAIT (1 cycle):
    - mem_read_en=0.
    - Register mem_read_data into slave_bus[17:0] and set meta=S_DATA on the transition to PRESENT.
  - PRESENT:
    - Hold slave_bus stable.
    - On a valid ack: seq toggles, cnt+1, meta returns to S_IDLE next cycle.
    - Then go to DONE if cnt+1==len, else to FETCH.
  - DONE:
    - slave_bus: meta=S_DONE, data = len zero-extended to 18 bits, [23]=seq.
    - On a valid ack: seq toggles, stream_done=1 for one cycle, go to IDLE.
- busy=1 in every state except IDLE.
- accel_done while busy is ignored; no queueing.
- Latency:
  - accel_done sampled at cycle t: mem_read_en at t+1, first S_DATA visible at t+3.
  - Valid ack sampled at cycle a: next read at a+1, next word at a+3.
  - Last ack at a: S_DONE visible at a+1.
- Simultaneous events:
  - rst/RST beats everything.
  - accel_done together with a stale ack in IDLE: start only.
- slave_bus[23] is stable whenever meta != S_IDLE.
- The data field is zero whenever meta==S_IDLE.

Test Plan:
- Basic stream:
  - Stimulus: memory[0x0100..0x0102]={0x00011,0x3FFFF,0x12345}; offset=0x0100, len=3; pulse accel_done.
  - Response: three S_DATA frames with seq 0,1,0 and those data values, each released by a matching ack; then S_DONE with data=3, seq=1; after its ack, stream_done pulses and busy falls.
  - Check mem_read_en at t+1 and first frame at t+3.
- Held and wrong acks:
  - Stimulus: hold OUTPUT_ACK with data[0]=0 for 5 cycles on word 0; then send data[0]=0 again on word 1 (seq=1).
  - Response: exactly one advance from the 5-cycle hold; word 1 stays presented until an ack with data[0]=1 arrives.
- Zero length:
  - Stimulus: len=0, accel_done.
  - Response: no mem_read_en; S_DONE with data=0 at t+1; ack gives stream_done.
- Address wrap:
  - Stimulus: offset=0xFFFF, len=2.
  - Response: mem_read_addr sequence 0xFFFF then 0x0000.
- Reset mid-stream:
  - Stimulus: master meta=RST, then rst=1, each applied during PRESENT of word 1 of 3.
  - Response: next cycle all outputs are 0, state is IDLE, no stream_done; a later accel_done restarts with seq=0 from word 0.
- Busy start:
  - Stimulus: accel_done pulsed during FETCH and during PRESENT.
  - Response: ignored; cnt, base and len are unchanged and the stream completes normally.
